// File: rtl/param_counter_pkg.sv
// ============================================================================
// Module      : param_counter_pkg
// Description : Shared definitions for the parametrised event counter:
//               direction encoding, load clamping helper and the event-flag
//               record produced by param_counter_evt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package param_counter_pkg;

  // Encoding of the up_dn input
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Registered event flags: one-cycle wrap pulses plus the sticky summary
  typedef struct packed {
    logic ovf;
    logic unf;
    logic sticky;
  } evt_flags_t;

  // Load values above the top of the count range are pinned to that top
  function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                               input logic [31:0] max_count);
    return (value > max_count) ? max_count : value;
  endfunction

endpackage : param_counter_pkg

`default_nettype wire

// File: rtl/param_counter_evt.sv
// ============================================================================
// Module      : param_counter_evt
// Description : Event-flag generator for param_counter. Turns the per-cycle
//               wrap/bound requests into registered overflow and underflow
//               pulses and maintains the sticky event flag.
//               Macro PARAM_COUNTER_SATURATE_EN: a pulse fires only on the
//               first attempt past a bound; repeats are suppressed while the
//               count stays pinned at that bound.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_counter_evt
  import param_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ovf_req,     // enabled up-step attempted at the top bound
  input  logic       unf_req,     // enabled down-step attempted at zero
  input  logic       max_next,    // count will sit at the top bound after this edge
  input  logic       zero_next,   // count will sit at zero after this edge
  input  logic       sticky_clr,
  output evt_flags_t flags
);

  logic       w_ovf_fire;
  logic       w_unf_fire;
  evt_flags_t r_flags;

`ifdef PARAM_COUNTER_SATURATE_EN
  logic r_ovf_held;
  logic r_unf_held;

  // Remember that the bound was already reported until the count leaves it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf_held <= 1'b0;
      r_unf_held <= 1'b0;
    end else begin
      r_ovf_held <= (ovf_req | r_ovf_held) & max_next;
      r_unf_held <= (unf_req | r_unf_held) & zero_next;
    end
  end

  assign w_ovf_fire = ovf_req & ~r_ovf_held;
  assign w_unf_fire = unf_req & ~r_unf_held;
`else
  // Bound-tracking inputs only matter when saturating
  logic w_unused_sat;
  assign w_unused_sat = &{1'b0, max_next, zero_next};

  assign w_ovf_fire = ovf_req;
  assign w_unf_fire = unf_req;
`endif

  // Pulses last one cycle; a new event outranks a same-cycle sticky clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags <= '0;
    end else begin
      r_flags.ovf <= w_ovf_fire;
      r_flags.unf <= w_unf_fire;
      if (w_ovf_fire || w_unf_fire) begin
        r_flags.sticky <= 1'b1;
      end else if (sticky_clr) begin
        r_flags.sticky <= 1'b0;
      end
    end
  end

  assign flags = r_flags;

endmodule : param_counter_evt

`default_nettype wire

// File: rtl/param_counter.sv
// ============================================================================
// Module      : param_counter
// Description : Parametrised up/down event counter with modulus MAX_COUNT+1,
//               synchronous clear and clamped parallel load, registered
//               overflow/underflow pulses, terminal-count look-ahead and a
//               sticky event flag.
//               Macro PARAM_COUNTER_SATURATE_EN: count saturates at the
//               bounds instead of wrapping; tc_out then reports "at bound in
//               the current direction".
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_counter
  import param_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sticky_clr,
  output logic [WIDTH-1:0] counter_out,
  output logic             overflow_out,
  output logic             underflow_out,
  output logic             tc_out,
  output logic             sticky_out
);

  localparam logic [WIDTH-1:0] c_max   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] c_reset = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] c_zero  = '0;
`ifdef PARAM_COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] c_past_max  = c_max;
  localparam logic [WIDTH-1:0] c_past_zero = c_zero;
`else
  localparam logic [WIDTH-1:0] c_past_max  = c_zero;
  localparam logic [WIDTH-1:0] c_past_zero = c_max;
`endif

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_load_val;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_dir_up;
  logic             w_dir_dn;
  logic             w_step;
  logic             w_ovf_req;
  logic             w_unf_req;
  evt_flags_t       w_flags;

  // Bound detection is by comparison so the carry never decides a wrap
  assign w_at_max   = (r_count == c_max);
  assign w_at_zero  = (r_count == c_zero);
  assign w_dir_up   = (up_dn == DIR_UP);
  assign w_dir_dn   = (up_dn == DIR_DN);
  assign w_step     = enable & ~clear & ~load;
  assign w_ovf_req  = w_step & w_dir_up & w_at_max;
  assign w_unf_req  = w_step & w_dir_dn & w_at_zero;
  assign w_load_val = WIDTH'(clamp_to_max(32'(load_val), MAX_COUNT));

  // Next count: clear beats load beats an enabled step; otherwise hold
  always_comb begin
    w_count_nxt = r_count;
    if (clear) begin
      w_count_nxt = c_reset;
    end else if (load) begin
      w_count_nxt = w_load_val;
    end else if (enable) begin
      if (w_dir_up) begin
        w_count_nxt = w_at_max ? c_past_max : r_count + WIDTH'(1);
      end else begin
        w_count_nxt = w_at_zero ? c_past_zero : r_count - WIDTH'(1);
      end
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= c_reset;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  param_counter_evt u_evt (
    .clk        (clk),
    .reset_n    (reset_n),
    .ovf_req    (w_ovf_req),
    .unf_req    (w_unf_req),
    .max_next   (w_count_nxt == c_max),
    .zero_next  (w_count_nxt == c_zero),
    .sticky_clr (sticky_clr),
    .flags      (w_flags)
  );

`ifdef PARAM_COUNTER_SATURATE_EN
  assign tc_out = (w_dir_up & w_at_max) | (w_dir_dn & w_at_zero);
`else
  assign tc_out = w_step & ((w_dir_up & w_at_max) | (w_dir_dn & w_at_zero));
`endif

  assign counter_out   = r_count;
  assign overflow_out  = w_flags.ovf;
  assign underflow_out = w_flags.unf;
  assign sticky_out    = w_flags.sticky;

endmodule : param_counter

`default_nettype wire

// File: tb/tb_param_counter.sv
// ============================================================================
// Module      : tb_param_counter
// Description : Directed self-checking bench for param_counter. Instance dut
//               uses the defaults (WIDTH=4, modulus 16); instance dut9 uses
//               MAX_COUNT=9. Wrap or saturate expectations follow the
//               PARAM_COUNTER_SATURATE_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_counter;

  logic       clk;
  logic       reset_n;
  logic       enable, up_dn, clear, load, sticky_clr;
  logic [3:0] load_val;
  logic [3:0] counter_out;
  logic       overflow_out, underflow_out, tc_out, sticky_out;

  logic       b_enable, b_up_dn, b_clear, b_load, b_sticky_clr;
  logic [3:0] b_load_val;
  logic [3:0] b_counter_out;
  logic       b_overflow_out, b_underflow_out, b_tc_out, b_sticky_out;

  int n_tests = 0;
  int n_fail  = 0;

  param_counter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .up_dn         (up_dn),
    .clear         (clear),
    .load          (load),
    .load_val      (load_val),
    .sticky_clr    (sticky_clr),
    .counter_out   (counter_out),
    .overflow_out  (overflow_out),
    .underflow_out (underflow_out),
    .tc_out        (tc_out),
    .sticky_out    (sticky_out)
  );

  param_counter #(.WIDTH(4), .MAX_COUNT(9), .RESET_VAL(0)) dut9 (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (b_enable),
    .up_dn         (b_up_dn),
    .clear         (b_clear),
    .load          (b_load),
    .load_val      (b_load_val),
    .sticky_clr    (b_sticky_clr),
    .counter_out   (b_counter_out),
    .overflow_out  (b_overflow_out),
    .underflow_out (b_underflow_out),
    .tc_out        (b_tc_out),
    .sticky_out    (b_sticky_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 0; up_dn = 0; clear = 0; load = 0; sticky_clr = 0; load_val = '0;
    b_enable = 0; b_up_dn = 0; b_clear = 0; b_load = 0; b_sticky_clr = 0; b_load_val = '0;

    // Reset state
    #2;
    chk("rst_count", counter_out, 0);
    chk("rst_ovf", overflow_out, 0);
    chk("rst_unf", underflow_out, 0);
    chk("rst_sticky", sticky_out, 0);
    @(negedge clk);
    reset_n = 1'b1;

`ifndef PARAM_COUNTER_SATURATE_EN
    // Full up count with wrap at 15 -> 0
    enable = 1; up_dn = 1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) chk("tc_at_15_up", tc_out, 1);
      if (i == 1)  chk("tc_at_0_up", tc_out, 0);
      tick();
      chk($sformatf("up_cnt_%0d", i), counter_out, i % 16);
      chk($sformatf("up_ovf_%0d", i), overflow_out, (i == 16) ? 1 : 0);
      chk($sformatf("up_sticky_%0d", i), sticky_out, (i == 16) ? 1 : 0);
    end
    enable = 0;
    tick();
    chk("hold_cnt", counter_out, 0);
    chk("ovf_one_cycle", overflow_out, 0);
    chk("sticky_held", sticky_out, 1);

    // sticky_clr alone clears
    sticky_clr = 1;
    tick();
    chk("sticky_clr", sticky_out, 0);

    // Down wrap with sticky_clr in the same cycle: set wins
    enable = 1; up_dn = 0;
    #1;
    chk("tc_at_0_dn", tc_out, 1);
    tick();
    chk("dn_wrap_cnt", counter_out, 15);
    chk("dn_wrap_unf", underflow_out, 1);
    chk("sticky_set_wins", sticky_out, 1);
    tick();
    chk("dn_cnt_14", counter_out, 14);
    chk("dn_unf_drop", underflow_out, 0);
    chk("sticky_clr_next", sticky_out, 0);
    sticky_clr = 0; enable = 0;

    // MAX_COUNT=9: load 7 then count 8, 9, 0
    b_load = 1; b_load_val = 7;
    tick();
    chk("m9_load7", b_counter_out, 7);
    b_load = 0; b_enable = 1; b_up_dn = 1;
    tick();
    chk("m9_cnt8", b_counter_out, 8);
    tick();
    chk("m9_cnt9", b_counter_out, 9);
    chk("m9_tc9", b_tc_out, 1);
    chk("m9_ovf_pre", b_overflow_out, 0);
    tick();
    chk("m9_wrap0", b_counter_out, 0);
    chk("m9_ovf", b_overflow_out, 1);
    b_enable = 0;
    tick();
    chk("m9_ovf_drop", b_overflow_out, 0);
    chk("m9_sticky", b_sticky_out, 1);
`else
    // Saturating up count: reaches 15 and stays, one overflow pulse
    enable = 1; up_dn = 1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("sat_cnt_%0d", i), counter_out, i);
      chk($sformatf("sat_ovf_%0d", i), overflow_out, 0);
    end
    chk("sat_tc_up", tc_out, 1);
    for (int j = 1; j <= 3; j++) begin
      tick();
      chk($sformatf("sat_hold_%0d", j), counter_out, 15);
      chk($sformatf("sat_ovf_once_%0d", j), overflow_out, (j == 1) ? 1 : 0);
      chk($sformatf("sat_sticky_%0d", j), sticky_out, 1);
    end
    up_dn = 0;
    #1;
    chk("sat_tc_dn_at_15", tc_out, 0);
    enable = 0;
    tick();
`endif

    // Load outranks enable and suppresses tc_out at the bound
    load = 1; load_val = 15; enable = 0;
    tick();
    chk("load15", counter_out, 15);
    load_val = 3; enable = 1; up_dn = 1;
    #1;
`ifndef PARAM_COUNTER_SATURATE_EN
    chk("tc_gated_by_load", tc_out, 0);
`endif
    tick();
    chk("load3", counter_out, 3);
    chk("load_no_ovf", overflow_out, 0);
    load_val = 5; enable = 0;
    tick();
    chk("load5", counter_out, 5);

    // clear + load + enable together -> RESET_VAL, no pulses
    clear = 1; load = 1; load_val = 9; enable = 1; up_dn = 1;
    tick();
    chk("clr_prio_cnt", counter_out, 0);
    chk("clr_prio_ovf", overflow_out, 0);
    chk("clr_prio_unf", underflow_out, 0);
    clear = 0; load = 0; enable = 0;

    // Load above MAX_COUNT clamps
    b_load = 1; b_load_val = 12;
    tick();
    chk("m9_clamp", b_counter_out, 9);
    b_load = 0;

    // Asynchronous reset mid-count
    enable = 1; up_dn = 1;
    repeat (6) tick();
    chk("pre_rst_cnt6", counter_out, 6);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_cnt", counter_out, 0);
    chk("async_rst_ovf", overflow_out, 0);
    chk("async_rst_sticky", sticky_out, 0);
    chk("async_rst_m9_cnt", b_counter_out, 0);
    chk("async_rst_m9_sticky", b_sticky_out, 0);
    #1;
    reset_n = 1'b1;
    tick();
    chk("resume_1", counter_out, 1);
    tick();
    chk("resume_2", counter_out, 2);
    enable = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_param_counter

`default_nettype wire
